// File: rtl/vending_ctrl_fsm_pkg.sv
// Shared definitions for the vending controller: widths, coin values, item prices
// and the sequencer state encoding.
package vending_ctrl_fsm_pkg;

  localparam int kNumItems  = 4;
  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 31;

  localparam logic [kTotalBits-1:0] kTotalMax = {kTotalBits{1'b1}};

  localparam logic [kTotalBits-1:0] kCoinValue100  = kTotalBits'(100);
  localparam logic [kTotalBits-1:0] kCoinValue500  = kTotalBits'(500);
  localparam logic [kTotalBits-1:0] kCoinValue1000 = kTotalBits'(1000);

  localparam logic [kNumCoins-1:0] kCoinMask100  = kNumCoins'(1);
  localparam logic [kNumCoins-1:0] kCoinMask500  = kNumCoins'(2);
  localparam logic [kNumCoins-1:0] kCoinMask1000 = kNumCoins'(4);

  localparam logic [kTotalBits-1:0] kPriceItem0 = kTotalBits'(400);
  localparam logic [kTotalBits-1:0] kPriceItem1 = kTotalBits'(500);
  localparam logic [kTotalBits-1:0] kPriceItem2 = kTotalBits'(1000);
  localparam logic [kTotalBits-1:0] kPriceItem3 = kTotalBits'(2000);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  function automatic logic [kTotalBits-1:0] coinValue(input int idx);
    case (idx)
      0:       coinValue = kCoinValue100;
      1:       coinValue = kCoinValue500;
      2:       coinValue = kCoinValue1000;
      default: coinValue = '0;
    endcase
  endfunction

  function automatic logic [kTotalBits-1:0] itemPrice(input int idx);
    case (idx)
      0:       itemPrice = kPriceItem0;
      1:       itemPrice = kPriceItem1;
      2:       itemPrice = kPriceItem2;
      3:       itemPrice = kPriceItem3;
      default: itemPrice = '0;
    endcase
  endfunction

  // Total value of every coin bit set in one cycle; at most 1600, so it cannot wrap.
  function automatic logic [kTotalBits-1:0] coinSum(input logic [kNumCoins-1:0] coins);
    logic [kTotalBits-1:0] sum;
    sum = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (coins[i]) begin
        sum = sum + coinValue(i);
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/vending_ctrl_fsm_coin_return_picker.sv
// Picks the largest coin that still fits in the remaining credit, with its value.
module vending_ctrl_fsm_coin_return_picker
  import vending_ctrl_fsm_pkg::*;
(
  input  logic [kTotalBits-1:0] credit_i,
  output logic [kNumCoins-1:0]  coin_o,
  output logic [kTotalBits-1:0] value_o
);

  always_comb begin
    coin_o  = '0;
    value_o = '0;
    if (credit_i >= kCoinValue1000) begin
      coin_o  = kCoinMask1000;
      value_o = kCoinValue1000;
    end else if (credit_i >= kCoinValue500) begin
      coin_o  = kCoinMask500;
      value_o = kCoinValue500;
    end else if (credit_i >= kCoinValue100) begin
      coin_o  = kCoinMask100;
      value_o = kCoinValue100;
    end
  end

endmodule

// File: rtl/vending_ctrl_fsm.sv
// Vending machine sequencer: credit accumulation, item grant, inactivity timeout
// and one-coin-per-handshake payout to the hopper.
module vending_ctrl_fsm
  import vending_ctrl_fsm_pkg::*;
#(
  parameter int WAIT_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  input  logic                  i_hopper_ready,
  output logic [kTotalBits-1:0] o_current_total,
  output logic [kNumItems-1:0]  o_available_item,
  output logic [kNumItems-1:0]  o_output_item,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_coin_reject,
  output logic                  o_busy
);

  localparam int kTimerBits = $clog2(WAIT_CYCLES + 1);
  localparam logic [kTimerBits-1:0] kTimerReload = kTimerBits'(WAIT_CYCLES);
  localparam logic [kTimerBits-1:0] kTimerOne    = kTimerBits'(1);

  state_e                state_q, state_d;
  logic [kTotalBits-1:0] total_q, total_d;
  logic [kTimerBits-1:0] timer_q, timer_d;
  logic [kNumItems-1:0]  outputItem_q, outputItem_d;
  logic                  coinReject_q, coinReject_d;

  logic [kNumCoins-1:0]  pickCoin;
  logic [kTotalBits-1:0] pickValue;
  logic [kNumItems-1:0]  selOneHot;
  logic [kTotalBits-1:0] selPrice;
  logic [kTotalBits-1:0] insertedValue;
  logic [kTotalBits-1:0] afterSel;
  logic [kTotalBits:0]   sumWide;
  logic [kTotalBits-1:0] afterRet;
  logic                  reload;

  vending_ctrl_fsm_coin_return_picker u_coin_return_picker (
    .credit_i (total_q),
    .coin_o   (pickCoin),
    .value_o  (pickValue)
  );

  // Lowest requested item wins; isolate its bit and look up its price.
  always_comb begin
    selOneHot = i_select_item & (~i_select_item + kNumItems'(1));
    selPrice  = '0;
    for (int i = 0; i < kNumItems; i++) begin
      if (selOneHot[i]) begin
        selPrice = itemPrice(i);
      end
    end
  end

  assign insertedValue = coinSum(i_input_coin);

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    timer_d      = timer_q;
    outputItem_d = '0;
    coinReject_d = 1'b0;
    afterSel     = total_q;
    sumWide      = '0;
    afterRet     = total_q;
    reload       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // Price is checked against credit before this cycle's coins are added.
        if ((|selOneHot) && (selPrice <= total_q)) begin
          afterSel     = total_q - selPrice;
          outputItem_d = selOneHot;
          reload       = 1'b1;
        end
        total_d = afterSel;
        sumWide = {1'b0, afterSel} + {1'b0, insertedValue};
        if (|i_input_coin) begin
          if (sumWide > {1'b0, kTotalMax}) begin
            coinReject_d = 1'b1;
          end else begin
            total_d = sumWide[kTotalBits-1:0];
            reload  = 1'b1;
          end
        end

        if (i_trigger_return && (total_d != '0)) begin
          state_d = ST_RETURN;
          timer_d = '0;
        end else if ((state_q == ST_CREDIT) && !reload && (timer_q <= kTimerOne)) begin
          state_d = ST_RETURN;
          timer_d = '0;
        end else if (total_d != '0) begin
          state_d = ST_CREDIT;
          timer_d = reload ? kTimerReload : (timer_q - kTimerOne);
        end else begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end

      ST_RETURN: begin
        coinReject_d = |i_input_coin;
        timer_d      = '0;
        if ((pickCoin != '0) && i_hopper_ready) begin
          afterRet = total_q - pickValue;
        end
        // Anything smaller than the smallest coin cannot be paid out, so it is dropped.
        if (afterRet < kCoinValue100) begin
          total_d = '0;
          state_d = ST_IDLE;
        end else begin
          total_d = afterRet;
        end
      end

      default: begin
        state_d = ST_IDLE;
        total_d = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      total_q      <= '0;
      timer_q      <= '0;
      outputItem_q <= '0;
      coinReject_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      timer_q      <= timer_d;
      outputItem_q <= outputItem_d;
      coinReject_q <= coinReject_d;
    end
  end

  always_comb begin
    o_available_item = '0;
    for (int i = 0; i < kNumItems; i++) begin
      o_available_item[i] = (itemPrice(i) <= total_q);
    end
  end

  assign o_current_total = total_q;
  assign o_output_item   = outputItem_q;
  assign o_coin_reject   = coinReject_q;
  assign o_busy          = (state_q == ST_RETURN);
  assign o_return_coin   = (state_q == ST_RETURN) ? pickCoin : '0;

endmodule

// File: doc/vending_ctrl_fsm.md
# vending_ctrl_fsm

Central sequencer for the vending machine. It accumulates inserted credit, grants item selections, and runs the inactivity timeout. It also drives coin return to the hopper one coin per handshake, largest denomination first. It owns the credit register and replaces the free-running wait/return logic, so the item and coin datapath only sees one coherent set of controls.

## Interface
- WAIT_CYCLES, 100, idle cycles after the last accepted coin or dispense before automatic return
- kNumItems, 4, item count (shared def)
- kNumCoins, 3, coin types (shared def)
- kTotalBits, 31, credit width (shared def)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- i_input_coin  in  kNumCoins  coins inserted this cycle; bit0=100, bit1=500, bit2=1000; multiple bits allowed
- i_select_item  in  kNumItems  item request; bit0..3 priced 400/500/1000/2000
- i_trigger_return  in  1  user return request, level-sampled
- i_hopper_ready  in  1  hopper accepts the presented coin this cycle
- o_current_total  out  kTotalBits  registered credit
- o_available_item  out  kNumItems  combinational: bit i set iff price[i] ≤ o_current_total
- o_output_item  out  kNumItems  registered one-hot dispense pulse, one cycle wide
- o_return_coin  out  kNumCoins  one-hot coin offered to the hopper; 0 when none
- o_coin_reject  out  1  registered one-cycle pulse: an inserted coin was not credited
- o_busy  out  1  high in RETURN

## Operation
- States: IDLE (credit 0), CREDIT (credit > 0, timer running), RETURN (paying out).
- IDLE/CREDIT, per edge, in this order:
  - Selection. Lowest set bit of i_select_item wins. It is granted iff its price ≤ credit *before* this cycle's coins. On grant: credit −= price, o_output_item = that bit next cycle, timer reloads. Otherwise the selection is ignored.
  - Coins. The sum of the set bits is added. If the new credit would exceed 2^kTotalBits−1, the whole cycle's coins are rejected and o_coin_reject pulses. Any accepted coin reloads the timer to WAIT_CYCLES.
  - Next state:
    - i_trigger_return with resulting credit > 0 → RETURN.
    - Otherwise, timer reaching 0 in CREDIT → RETURN.
    - Otherwise, credit > 0 → CREDIT, else IDLE.
    - i_trigger_return with credit 0 → stays IDLE, no effect.
- Timer: decrements by 1 each CREDIT cycle without a reload. It is held at 0 in IDLE and RETURN.
- RETURN:
  - o_return_coin = largest coin ≤ credit, priority 1000 > 500 > 100.
  - A coin transfers on an edge where o_return_coin ≠ 0 and i_hopper_ready = 1; credit −= its value.
  - Credit 0 → IDLE. A residue below 100 is cleared to 0, → IDLE.
  - Selections are ignored. Coins are not credited and o_coin_reject pulses.
- o_return_coin = 0 outside RETURN.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, credit 0, timer 0, o_output_item 0, o_coin_reject 0. o_return_coin and o_busy are 0 via state. Reset mid-RETURN discards the remaining credit.
- Coin at edge N: o_current_total reflects it after N.
- Selection at edge N: o_output_item high for cycle N..N+1, credit already reduced.
- Timeout: last reload at edge N → enters RETURN at edge N+WAIT_CYCLES.
- Return throughput: one coin per cycle while i_hopper_ready stays high. A hopper stall holds o_return_coin stable.
- Simultaneous valid select plus coins: both apply in the same edge.
- Simultaneous select plus trigger: the dispense happens, then the remainder returns.

## Structure
- Shared def file holds:
  - kNumItems, kNumCoins, kTotalBits
  - coin value and item price constants
  - state encoding defines (IDLE/CREDIT/RETURN)
- One sub-module, coin_return_picker: combinational, credit → one-hot largest coin and its value. Instantiated for o_return_coin.

## Test plan
- Insert 1000 then select item1 (500): o_output_item = 0010 for one cycle, credit 500, o_available_item = 0011.
- Credit 1600, i_trigger_return, hopper always ready: o_return_coin sequence 100/010/001, then IDLE. o_busy high for 3 cycles, credit 0.
- Credit 300, no activity: RETURN entered exactly WAIT_CYCLES edges after the last coin; three 001 coins.
- Credit 1000, hopper ready low for 5 cycles: o_return_coin holds 100 and credit holds 1000; after ready rises, credit goes to 0 in one edge.
- Credit 300, select item0 (400) with a 100 coin in the same cycle: no dispense, credit 400. Selecting again next cycle dispenses and leaves credit 0.
- Reset asserted mid-RETURN at credit 1500: all outputs 0 immediately, credit 0. After release the FSM is in IDLE.
